// File: rtl/button_plant_3x4_emulator.sv
// Keypad-side model of a 3x4 key matrix: presses one commanded key for a programmed time, then releases it for a fixed gap.
// Define BUTTON_PLANT_BOUNCE_EN to emulate contact bounce at the start of each press and each release.
module button_plant_3x4_emulator #(
    parameter int HOLD_W        = 16,
    parameter int GAP_CYCLES    = 64,
    parameter int BOUNCE_CYCLES = 16
) (
    input  logic              aclk,
    input  logic              areset,
    input  logic              I_BUTTON_COL_0,
    input  logic              I_BUTTON_COL_1,
    input  logic              I_BUTTON_COL_2,
    output logic              O_BUTTON_ROW_0,
    output logic              O_BUTTON_ROW_1,
    output logic              O_BUTTON_ROW_2,
    output logic              O_BUTTON_ROW_3,
    input  logic              i_cmd_valid,
    output logic              o_cmd_ready,
    input  logic [3:0]        i_cmd_key,
    input  logic [HOLD_W-1:0] i_cmd_hold,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_err
);

    localparam int GAP_W = $clog2(GAP_CYCLES + 1);

    typedef enum logic [1:0] {
        IDLE,
        PRESS,
        GAP
    } state_t;

    state_t            state, state_next;
    logic [2:0]        col_meta, col_sync;
    logic [3:0]        key_q;
    logic [HOLD_W-1:0] hold_cnt;
    logic [GAP_W-1:0]  gap_cnt;
    logic [3:0]        row_q, row_next;
    logic [1:0]        key_row, key_col;
    logic              col_hit;
    logic              pressed_eff;
    logic              transfer, key_bad;

    assign transfer = i_cmd_valid && o_cmd_ready;
    assign key_bad  = (i_cmd_key > 4'd11);

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        state_next = state;
        case (state)
            IDLE:    if (transfer && !key_bad) state_next = PRESS;
            PRESS:   if (hold_cnt <= HOLD_W'(1)) state_next = GAP;
            GAP:     if (gap_cnt <= GAP_W'(1)) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Key k sits at row k/3, column k%3.
    always_comb begin
        key_row = 2'd0;
        key_col = 2'd0;
        case (key_q)
            4'd0, 4'd1, 4'd2:   key_row = 2'd0;
            4'd3, 4'd4, 4'd5:   key_row = 2'd1;
            4'd6, 4'd7, 4'd8:   key_row = 2'd2;
            4'd9, 4'd10, 4'd11: key_row = 2'd3;
            default:            key_row = 2'd0;
        endcase
        case (key_q)
            4'd1, 4'd4, 4'd7, 4'd10: key_col = 2'd1;
            4'd2, 4'd5, 4'd8, 4'd11: key_col = 2'd2;
            default:                 key_col = 2'd0;
        endcase
    end

    always_comb begin
        col_hit = 1'b0;
        case (key_col)
            2'd0:    col_hit = !col_sync[0];
            2'd1:    col_hit = !col_sync[1];
            2'd2:    col_hit = !col_sync[2];
            default: col_hit = 1'b0;
        endcase
        row_next = 4'hF;
        if (pressed_eff && col_hit) row_next[key_row] = 1'b0;
    end

`ifdef BUTTON_PLANT_BOUNCE_EN
    localparam int BOUNCE_W = $clog2(BOUNCE_CYCLES + 1);

    logic [15:0]         lfsr;
    logic [BOUNCE_W-1:0] phase_cnt;
    logic                in_window;

    assign in_window = (state != IDLE) && (phase_cnt < BOUNCE_W'(BOUNCE_CYCLES));

    always_comb begin
        pressed_eff = (state == PRESS);
        if (in_window) pressed_eff = lfsr[0];
    end

    // The LFSR free-runs in every state; the phase counter restarts on each state change.
    always_ff @(posedge aclk) begin
        if (areset) begin
            lfsr      <= 16'hACE1;
            phase_cnt <= '0;
        end else begin
            lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
            if (state_next != state)
                phase_cnt <= '0;
            else if (phase_cnt < BOUNCE_W'(BOUNCE_CYCLES))
                phase_cnt <= phase_cnt + BOUNCE_W'(1);
        end
    end
`else
    assign pressed_eff = (state == PRESS);
`endif

    always_ff @(posedge aclk) begin
        // NOTE: the synchronizer flops are reset to the released level so no phantom scan appears after reset.
        if (areset) begin
            state    <= IDLE;
            col_meta <= 3'b111;
            col_sync <= 3'b111;
            key_q    <= '0;
            hold_cnt <= '0;
            gap_cnt  <= '0;
            row_q    <= 4'hF;
            o_err    <= 1'b0;
        end else begin
            state    <= state_next;
            col_meta <= {I_BUTTON_COL_2, I_BUTTON_COL_1, I_BUTTON_COL_0};
            col_sync <= col_meta;
            row_q    <= row_next;
            o_err    <= transfer && key_bad;
            case (state)
                IDLE: begin
                    if (transfer && !key_bad) begin
                        key_q    <= i_cmd_key;
                        hold_cnt <= (i_cmd_hold == '0) ? HOLD_W'(1) : i_cmd_hold;
                    end
                end
                PRESS: begin
                    if (hold_cnt <= HOLD_W'(1)) begin
                        hold_cnt <= '0;
                        gap_cnt  <= GAP_W'(GAP_CYCLES);
                    end else begin
                        hold_cnt <= hold_cnt - HOLD_W'(1);
                    end
                end
                GAP: begin
                    if (gap_cnt != '0) gap_cnt <= gap_cnt - GAP_W'(1);
                end
                default: ;
            endcase
        end
    end

    assign o_cmd_ready    = (state == IDLE);
    assign o_busy         = (state != IDLE);
    assign o_done         = (state == GAP) && (gap_cnt == GAP_W'(1));
    assign O_BUTTON_ROW_0 = row_q[0];
    assign O_BUTTON_ROW_1 = row_q[1];
    assign O_BUTTON_ROW_2 = row_q[2];
    assign O_BUTTON_ROW_3 = row_q[3];

endmodule
